// File: rtl/deadlock_mon_pkg.sv
// Shared types for the kernel deadlock monitor: FSM states, event counter width, saturating increment.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package deadlock_mon_pkg;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        SUSPECT = 2'd1,
        BLOCKED = 2'd2
    } dl_state_e;

    localparam int EVENT_CNT_W = 16;

    function automatic logic [EVENT_CNT_W-1:0] sat_inc(input logic [EVENT_CNT_W-1:0] v);
        return (&v) ? v : v + EVENT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/deadlock_lsb_encoder.sv
// Priority encoder: index of the lowest set bit of vec, 0 when vec is empty.
// Latency: combinational.
// Backpressure: none.
module deadlock_lsb_encoder #(
    parameter  int N     = 5,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/deadlock_axis_stall_detector.sv
// Flags a kernel block when all non-idle AXIS owners stay stalled with a stable mask, or on any inst block.
// Latency: block registers on the STALL_THRESH-th stable stalled edge, or the edge sampling an inst block.
// Backpressure: none (passive monitor); DEADLOCK_CULPRIT_EN adds the lowest stalled channel index output.
module deadlock_axis_stall_detector
    import deadlock_mon_pkg::*;
#(
    parameter  int N_AXIS       = 5,
    parameter  int N_INST       = 1,
    parameter  int STALL_THRESH = 16,
    parameter  int STICKY       = 1,
    localparam int CULPRIT_W    = (N_AXIS > 1) ? $clog2(N_AXIS) : 1,
    localparam int CNT_W        = $clog2(STALL_THRESH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_AXIS-1:0]      axis_block_sigs,
    input  logic [N_AXIS-1:0]      inst_idle_sigs,
    input  logic [N_INST-1:0]      inst_block_sigs,
    output logic                   block,
    output logic [N_AXIS-1:0]      block_mask,
    output logic [EVENT_CNT_W-1:0] event_cnt,
    output logic [CULPRIT_W-1:0]   first_culprit
);

    logic [N_AXIS-1:0] act;
    logic [N_AXIS-1:0] stl;
    logic              cand;
    logic              hard;
    logic              enter;

    dl_state_e              state_d, state_q;
    logic [CNT_W-1:0]       cnt_d, cnt_q;
    logic [N_AXIS-1:0]      snap_d, snap_q;
    logic                   block_d, block_q;
    logic [N_AXIS-1:0]      mask_d, mask_q;
    logic [EVENT_CNT_W-1:0] evt_d, evt_q;

    always_comb begin
        act  = ~inst_idle_sigs;
        stl  = axis_block_sigs & act;
        cand = (|act) && (stl == act);
        hard = |inst_block_sigs;

        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        block_d = block_q;
        mask_d  = mask_q;
        evt_d   = evt_q;
        enter   = 1'b0;

        case (state_q)
            MONITOR: begin
                if (hard) begin
                    enter = 1'b1;
                end else if (cand) begin
                    state_d = SUSPECT;
                    cnt_d   = CNT_W'(1);
                    snap_d  = stl;
                end else begin
                    cnt_d = '0;
                end
            end
            SUSPECT: begin
                if (hard) begin
                    enter = 1'b1;
                end else if (!cand) begin
                    state_d = MONITOR;
                    cnt_d   = '0;
                end else if (stl != snap_q) begin
                    // A different set of stalled channels is a new episode.
                    cnt_d  = CNT_W'(1);
                    snap_d = stl;
                end else if (cnt_q == CNT_W'(STALL_THRESH - 1)) begin
                    enter = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BLOCKED: begin
                if (STICKY == 0 && !cand && !hard) begin
                    state_d = MONITOR;
                    cnt_d   = '0;
                    block_d = 1'b0;
                end
            end
            default: state_d = MONITOR;
        endcase

        if (enter) begin
            state_d = BLOCKED;
            block_d = 1'b1;
            mask_d  = stl;
            evt_d   = sat_inc(evt_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MONITOR;
            cnt_q   <= '0;
            snap_q  <= '0;
            block_q <= 1'b0;
            mask_q  <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            block_q <= block_d;
            mask_q  <= mask_d;
            evt_q   <= evt_d;
        end
    end

    assign block      = block_q;
    assign block_mask = mask_q;
    assign event_cnt  = evt_q;

`ifdef DEADLOCK_CULPRIT_EN
    logic [CULPRIT_W-1:0] enc_idx;
    logic [CULPRIT_W-1:0] culprit_d, culprit_q;

    deadlock_lsb_encoder #(.N(N_AXIS)) u_lsb_enc (
        .vec (stl),
        .idx (enc_idx)
    );

    always_comb culprit_d = enter ? enc_idx : culprit_q;

    always_ff @(posedge clock) begin
        if (reset) culprit_q <= '0;
        else       culprit_q <= culprit_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && enter) $display("find kernel block. channel %0d", enc_idx);
    end
`endif

    assign first_culprit = culprit_q;
`else
    assign first_culprit = '0;
`endif

endmodule

// File: tb/tb_deadlock_axis_stall_detector.sv
// Bench for deadlock_axis_stall_detector: sticky and non-sticky instances share stimulus,
// each compared every cycle against a streak-based reference model.
module tb_deadlock_axis_stall_detector;

    localparam int NA = 5;
    localparam int TH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NA-1:0] axis  = '0;
    logic [NA-1:0] idle  = '0;
    logic [0:0]    iblk  = '0;

    logic          blk_s, blk_n;
    logic [NA-1:0] mask_s, mask_n;
    logic [15:0]   evt_s, evt_n;
    logic [2:0]    cul_s, cul_n;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    deadlock_axis_stall_detector #(
        .N_AXIS(NA), .N_INST(1), .STALL_THRESH(TH), .STICKY(1)
    ) dut_sticky (
        .clock(clock), .reset(reset),
        .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
        .block(blk_s), .block_mask(mask_s), .event_cnt(evt_s), .first_culprit(cul_s)
    );

    deadlock_axis_stall_detector #(
        .N_AXIS(NA), .N_INST(1), .STALL_THRESH(TH), .STICKY(0)
    ) dut_release (
        .clock(clock), .reset(reset),
        .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
        .block(blk_n), .block_mask(mask_n), .event_cnt(evt_n), .first_culprit(cul_n)
    );

    // Reference: length of the current run of edges where every busy channel is
    // stalled with an unchanged stalled set; index 0 = sticky, 1 = releasing.
    int            run_len = 0;
    logic [NA-1:0] run_stl = '0;
    logic          m_blk [2];
    logic [NA-1:0] m_mask[2];
    int            m_evt [2];
    int            m_cul [2];

    function automatic int lowest_set(input logic [NA-1:0] v);
        for (int i = 0; i < NA; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        logic [NA-1:0] busy, stalled;
        logic          all_stalled, hard;
        if (reset) begin
            run_len = 0;
            run_stl = '0;
            for (int m = 0; m < 2; m++) begin
                m_blk[m] = 1'b0; m_mask[m] = '0; m_evt[m] = 0; m_cul[m] = 0;
            end
            return;
        end
        busy        = ~idle;
        stalled     = axis & busy;
        all_stalled = (busy != 0) && ((axis & busy) == busy);
        hard        = (iblk != 0);
        if (all_stalled && run_len > 0 && stalled == run_stl) begin
            run_len++;
        end else begin
            run_len = all_stalled ? 1 : 0;
            run_stl = stalled;
        end
        for (int m = 0; m < 2; m++) begin
            if (!m_blk[m]) begin
                if (hard || run_len >= TH) begin
                    m_blk[m]  = 1'b1;
                    m_mask[m] = stalled;
                    m_evt[m]  = (m_evt[m] < 65535) ? m_evt[m] + 1 : 65535;
`ifdef DEADLOCK_CULPRIT_EN
                    m_cul[m]  = lowest_set(stalled);
`else
                    m_cul[m]  = 0;
`endif
                end
            end else if (m == 1 && !all_stalled && !hard) begin
                m_blk[m] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_step();
        check_val("cyc_block_s",   32'(blk_s),  32'(m_blk[0]));
        check_val("cyc_mask_s",    32'(mask_s), 32'(m_mask[0]));
        check_val("cyc_evt_s",     32'(evt_s),  32'(m_evt[0]));
        check_val("cyc_culprit_s", 32'(cul_s),  32'(m_cul[0]));
        check_val("cyc_block_n",   32'(blk_n),  32'(m_blk[1]));
        check_val("cyc_mask_n",    32'(mask_n), 32'(m_mask[1]));
        check_val("cyc_evt_n",     32'(evt_n),  32'(m_evt[1]));
        check_val("cyc_culprit_n", 32'(cul_n),  32'(m_cul[1]));
    endtask

    task automatic do_reset();
        reset = 1'b1; axis = '0; idle = '0; iblk = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_val("rst_block", 32'(blk_s),  32'd0);
        check_val("rst_mask",  32'(mask_s), 32'd0);
        check_val("rst_evt",   32'(evt_s),  32'd0);
        check_val("rst_cul",   32'(cul_s),  32'd0);

        // Single busy channel stalled for the threshold
        idle = 5'b11110; axis = 5'b00001;
        repeat (TH - 1) tick();
        check_val("t1_pre_block", 32'(blk_s), 32'd0);
        tick();
        check_val("t1_block", 32'(blk_s),  32'd1);
        check_val("t1_mask",  32'(mask_s), 32'h01);
        check_val("t1_evt",   32'(evt_s),  32'd1);
        check_val("t1_cul",   32'(cul_s),  32'd0);

        // One busy channel never stalls: no block
        do_reset();
        idle = 5'b00000; axis = 5'b11110;
        repeat (50) tick();
        check_val("t2_block_s", 32'(blk_s), 32'd0);
        check_val("t2_block_n", 32'(blk_n), 32'd0);

        // Stalled set changes mid-count: restart
        do_reset();
        idle = 5'b00000; axis = 5'b11111;
        repeat (3) tick();
        idle = 5'b00100;
        repeat (TH - 1) tick();
        check_val("t3_pre_block", 32'(blk_s), 32'd0);
        tick();
        check_val("t3_block", 32'(blk_s),  32'd1);
        check_val("t3_mask",  32'(mask_s), 32'h1b);

        // Hard block with nothing stalled
        do_reset();
        iblk = 1'b1; axis = '0; idle = '0;
        tick();
        iblk = 1'b0;
        check_val("t4_block", 32'(blk_s),  32'd1);
        check_val("t4_mask",  32'(mask_s), 32'd0);
        check_val("t4_evt",   32'(evt_s),  32'd1);

        // Non-sticky release and retrigger
        do_reset();
        idle = 5'b11110; axis = 5'b00001;
        repeat (TH) tick();
        check_val("t5_block_n", 32'(blk_n), 32'd1);
        axis = '0;
        tick();
        check_val("t5_release_n", 32'(blk_n), 32'd0);
        check_val("t5_held_s",    32'(blk_s), 32'd1);
        check_val("t5_mask_hold", 32'(mask_n), 32'h01);
        axis = 5'b00001;
        repeat (TH) tick();
        check_val("t5_evt_n", 32'(evt_n), 32'd2);
        check_val("t5_evt_s", 32'(evt_s), 32'd1);

        // Reset mid-suspect then full threshold again
        do_reset();
        idle = 5'b11110; axis = 5'b00001;
        repeat (TH - 1) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t6_rst_block", 32'(blk_s), 32'd0);
        check_val("t6_rst_evt",   32'(evt_s), 32'd0);
        repeat (TH - 1) tick();
        check_val("t6_pre_block", 32'(blk_s), 32'd0);
        tick();
        check_val("t6_block", 32'(blk_s), 32'd1);

        // Randomized segments of held patterns with glitches, hard blocks and resets
        do_reset();
        for (int seg = 0; seg < 600; seg++) begin
            int len;
            len  = $urandom_range(1, 8);
            idle = ($urandom_range(0, 4) == 0) ? 5'b11111 : NA'($urandom);
            axis = ($urandom_range(0, 2) != 0) ? (~idle | NA'($urandom)) : NA'($urandom);
            for (int c = 0; c < len; c++) begin
                int bit_sel;
                iblk  = 1'($urandom_range(0, 40) == 0);
                reset = ($urandom_range(0, 60) == 0);
                if ($urandom_range(0, 9) == 0) begin
                    bit_sel = $urandom_range(0, NA - 1);
                    axis[bit_sel] = ~axis[bit_sel];
                end
                tick();
            end
        end
        reset = 1'b0; iblk = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
